// File: rtl/twos_complement_decoder.sv
// Bit-serial two's-complement to sign-magnitude converter, LSB first, using the
// copy-until-first-one-then-invert rule, with valid/ready handshakes on both sides.
module twos_complement_decoder #(
   parameter int WIDTH = 4
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] input_value,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             sign,
   output logic [WIDTH-1:0] magnitude,
   output logic             min_neg
);

   localparam int               CW       = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0]    LAST_BIT = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_r;
   state_t           state_s;
   logic [WIDTH-1:0] shift_r;
   logic [WIDTH-1:0] acc_r;
   logic [CW-1:0]    count_r;
   logic             neg_r;
   logic             seen_one_r;
   logic             is_min_r;
   logic             out_valid_r;
   logic             sign_out_r;
   logic [WIDTH-1:0] magnitude_r;
   logic             min_neg_r;
   logic             last_s;
   logic             out_bit_s;

   assign last_s    = (count_r == LAST_BIT);
   assign in_ready  = (state_r == IDLE);
   assign out_valid = out_valid_r;
   assign sign      = sign_out_r;
   assign magnitude = magnitude_r;
   assign min_neg   = min_neg_r;

   // Next-state decode and the serial output bit for the current LSB.
   always_comb begin
      state_s   = state_r;
      out_bit_s = shift_r[0];
      case (state_r)
         IDLE: begin
            if (in_valid) state_s = SHIFT;
            else          state_s = IDLE;
         end
         SHIFT: begin
            if (last_s) state_s = DONE;
            else        state_s = SHIFT;
         end
         DONE: begin
            if (out_ready) state_s = IDLE;
            else           state_s = DONE;
         end
         default: state_s = IDLE;
      endcase
      // Once a one has passed, every higher bit of a negative word is inverted.
      if (neg_r && seen_one_r) out_bit_s = ~shift_r[0];
      else                     out_bit_s = shift_r[0];
   end

   // State register.
   always_ff @(posedge clock) begin
      if (!reset_n) state_r <= IDLE;
      else          state_r <= state_s;
   end

   // Serial datapath: word capture on accept, one bit converted per SHIFT cycle.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         shift_r    <= {WIDTH{1'b0}};
         acc_r      <= {WIDTH{1'b0}};
         count_r    <= {CW{1'b0}};
         neg_r      <= 1'b0;
         seen_one_r <= 1'b0;
         is_min_r   <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid) begin
                  shift_r    <= input_value;
                  acc_r      <= {WIDTH{1'b0}};
                  count_r    <= {CW{1'b0}};
                  neg_r      <= input_value[WIDTH-1];
                  seen_one_r <= 1'b0;
                  is_min_r   <= (input_value == MOST_NEG);
               end
            end
            SHIFT: begin
               shift_r <= shift_r >> 1;
               acc_r   <= {out_bit_s, acc_r[WIDTH-1:1]};
               count_r <= count_r + CW'(1);
               if (neg_r) seen_one_r <= seen_one_r | shift_r[0];
            end
            DONE: begin
               count_r <= count_r;
            end
            default: begin
               count_r <= {CW{1'b0}};
            end
         endcase
      end
   end

   // Result registers: loaded on the final shift, held through backpressure.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         out_valid_r <= 1'b0;
         sign_out_r  <= 1'b0;
         magnitude_r <= {WIDTH{1'b0}};
         min_neg_r   <= 1'b0;
      end else begin
         case (state_r)
            SHIFT: begin
               if (last_s) begin
                  out_valid_r <= 1'b1;
                  sign_out_r  <= neg_r;
                  magnitude_r <= {out_bit_s, acc_r[WIDTH-1:1]};
                  min_neg_r   <= neg_r && is_min_r;
               end
            end
            DONE: begin
               if (out_ready) out_valid_r <= 1'b0;
            end
            IDLE: begin
               out_valid_r <= 1'b0;
            end
            default: begin
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_twos_complement_decoder.sv
// Directed self-checking bench for twos_complement_decoder at WIDTH=4.
module tb_twos_complement_decoder;

   localparam int WIDTH = 4;

   logic             clock;
   logic             reset_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] input_value;
   logic             out_valid;
   logic             out_ready;
   logic             sign;
   logic [WIDTH-1:0] magnitude;
   logic             min_neg;

   int vectors;
   int miscompares;

   twos_complement_decoder #(.WIDTH(WIDTH)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .input_value (input_value),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .sign        (sign),
      .magnitude   (magnitude),
      .min_neg     (min_neg)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Waits for in_ready, presents one word, and returns the number of edges
   // (accept edge counted as 1) until out_valid is seen; 0 means timeout.
   task automatic run_word(input logic [WIDTH-1:0] w, output int lat);
      int guard;
      guard = 0;
      while (!in_ready && guard < 20) begin
         @(negedge clock);
         guard++;
      end
      in_valid    = 1'b1;
      input_value = w;
      lat = 0;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clock);
         in_valid = 1'b0;
         if (out_valid) begin
            lat = c;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset_n     = 1'b0;
      in_valid    = 1'b0;
      out_ready   = 1'b0;
      input_value = 4'b0000;
      repeat (2) @(negedge clock);
      vectors++;
      if ({in_ready, out_valid, sign, magnitude, min_neg} !== {1'b1, 1'b0, 1'b0, 4'b0000, 1'b0}) begin
         miscompares++;
         $display("FAIL reset: got rdy/vld/sign/mag/min=%b expected 1000000",
                  {in_ready, out_valid, sign, magnitude, min_neg});
      end
      reset_n = 1'b1;
      @(negedge clock);
   endtask

   task automatic test_single();
      int lat;
      out_ready = 1'b1;
      run_word(4'b0001, lat);
      vectors++;
      if (lat !== 5) begin
         miscompares++;
         $display("FAIL single_latency: got %0d expected 5", lat);
      end
      vectors++;
      if ({sign, magnitude, min_neg} !== {1'b0, 4'b0001, 1'b0}) begin
         miscompares++;
         $display("FAIL single_result: got sign/mag/min=%b expected 000010",
                  {sign, magnitude, min_neg});
      end
      @(negedge clock);
      vectors++;
      if ({in_ready, out_valid} !== 2'b10) begin
         miscompares++;
         $display("FAIL single_release: got rdy/vld=%b expected 10", {in_ready, out_valid});
      end
   endtask

   task automatic test_back_to_back();
      logic [WIDTH-1:0] words [4];
      logic [5:0]       exp_res [4];
      int idx, k, cyc, last_cyc;
      logic acc;
      words[0] = 4'b1111; exp_res[0] = {1'b1, 4'b0001, 1'b0};
      words[1] = 4'b1010; exp_res[1] = {1'b1, 4'b0110, 1'b0};
      words[2] = 4'b0111; exp_res[2] = {1'b0, 4'b0111, 1'b0};
      words[3] = 4'b0000; exp_res[3] = {1'b0, 4'b0000, 1'b0};
      out_ready   = 1'b1;
      in_valid    = 1'b1;
      input_value = words[0];
      idx = 0; k = 0; cyc = 0; last_cyc = 0;
      while (k < 4 && cyc < 100) begin
         acc = in_ready && in_valid;
         @(negedge clock);
         cyc++;
         if (acc) begin
            idx++;
            if (idx < 4) input_value = words[idx];
            else         in_valid = 1'b0;
         end
         if (out_valid) begin
            vectors++;
            if ({sign, magnitude, min_neg} !== exp_res[k]) begin
               miscompares++;
               $display("FAIL b2b_result[%0d]: got sign/mag/min=%b expected %b",
                        k, {sign, magnitude, min_neg}, exp_res[k]);
            end
            if (k > 0) begin
               vectors++;
               if (cyc - last_cyc !== 6) begin
                  miscompares++;
                  $display("FAIL b2b_spacing[%0d]: got %0d expected 6", k, cyc - last_cyc);
               end
            end
            last_cyc = cyc;
            k++;
         end
      end
      in_valid = 1'b0;
      vectors++;
      if (k !== 4) begin
         miscompares++;
         $display("FAIL b2b_count: got %0d results expected 4", k);
      end
      @(negedge clock);
   endtask

   task automatic test_min_neg();
      int lat;
      out_ready = 1'b1;
      run_word(4'b1000, lat);
      vectors++;
      if (lat !== 5 || {sign, magnitude, min_neg} !== {1'b1, 4'b1000, 1'b1}) begin
         miscompares++;
         $display("FAIL min_neg_1000: got lat=%0d sign/mag/min=%b expected lat=5 110001",
                  lat, {sign, magnitude, min_neg});
      end
      run_word(4'b1001, lat);
      vectors++;
      if (lat !== 5 || {sign, magnitude, min_neg} !== {1'b1, 4'b0111, 1'b0}) begin
         miscompares++;
         $display("FAIL min_neg_1001: got lat=%0d sign/mag/min=%b expected lat=5 101110",
                  lat, {sign, magnitude, min_neg});
      end
      @(negedge clock);
   endtask

   task automatic test_backpressure();
      int lat;
      out_ready = 1'b0;
      run_word(4'b1101, lat);
      vectors++;
      if (lat !== 5 || {sign, magnitude, min_neg} !== {1'b1, 4'b0011, 1'b0}) begin
         miscompares++;
         $display("FAIL bp_result: got lat=%0d sign/mag/min=%b expected lat=5 100110",
                  lat, {sign, magnitude, min_neg});
      end
      for (int c = 0; c < 7; c++) begin
         @(negedge clock);
         vectors++;
         if ({out_valid, in_ready, sign, magnitude, min_neg} !== {1'b1, 1'b0, 1'b1, 4'b0011, 1'b0}) begin
            miscompares++;
            $display("FAIL bp_hold[%0d]: got vld/rdy/sign/mag/min=%b expected 10100110",
                     c, {out_valid, in_ready, sign, magnitude, min_neg});
         end
      end
      out_ready = 1'b1;
      @(negedge clock);
      vectors++;
      if ({out_valid, in_ready} !== 2'b01) begin
         miscompares++;
         $display("FAIL bp_release: got vld/rdy=%b expected 01", {out_valid, in_ready});
      end
   endtask

   task automatic test_reset_mid_shift();
      int lat, pulses;
      out_ready   = 1'b1;
      in_valid    = 1'b1;
      input_value = 4'b1110;
      @(negedge clock);
      in_valid = 1'b0;
      @(negedge clock);
      reset_n = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      vectors++;
      if ({in_ready, out_valid, sign, magnitude, min_neg} !== {1'b1, 1'b0, 1'b0, 4'b0000, 1'b0}) begin
         miscompares++;
         $display("FAIL mid_reset: got rdy/vld/sign/mag/min=%b expected 1000000",
                  {in_ready, out_valid, sign, magnitude, min_neg});
      end
      pulses = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clock);
         if (out_valid) pulses++;
      end
      vectors++;
      if (pulses !== 0) begin
         miscompares++;
         $display("FAIL mid_reset_pulse: got %0d out_valid cycles expected 0", pulses);
      end
      run_word(4'b0101, lat);
      vectors++;
      if (lat !== 5 || {sign, magnitude, min_neg} !== {1'b0, 4'b0101, 1'b0}) begin
         miscompares++;
         $display("FAIL after_reset: got lat=%0d sign/mag/min=%b expected lat=5 001010",
                  lat, {sign, magnitude, min_neg});
      end
      @(negedge clock);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset();
      test_single();
      test_back_to_back();
      test_min_neg();
      test_backpressure();
      test_reset_mid_shift();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
